// File: rtl/timebase_pkg.sv
// Shared types and helpers for the clock timebase.
// Holds the mode encoding and parameter sanity checks.
package timebase_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        FAST   = 2'd2
    } state_e;

    function automatic int cnt_width(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic bit timebase_legal(
        input int unsigned clk_hz,
        input int unsigned scan_hz,
        input int unsigned blink_hz,
        input int unsigned fast_hz
    );
        if (scan_hz == 0 || blink_hz == 0 || fast_hz == 0)
            return 1'b0;
        return (clk_hz % scan_hz == 0)
            && (scan_hz % (2 * blink_hz) == 0)
            && (scan_hz % fast_hz == 0);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with enable and synchronous clear.
// wrap flags the enabled step from MOD-1 back to 0.
module mod_counter
    import timebase_pkg::*;
#(
    parameter int unsigned MOD = 2
) (
    input  logic                        clk_i,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        clr,
    output logic [cnt_width(MOD)-1:0]   cnt,
    output logic                        wrap
);

    localparam int W = cnt_width(MOD);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step and wrap at LAST.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/timebase_ctrl.sv
// Central tick scheduler: one prescaler feeding scan,
// seconds, fast-set and blink timebases under a mode FSM.
module timebase_ctrl
    import timebase_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned BLINK_HZ = 2,
    parameter int unsigned FAST_HZ  = 8
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic               run_i,
    input  logic               fast_i,
    input  logic               resync_i,
    output logic               scan_tick_o,
    output logic               sec_tick_o,
    output logic               fast_tick_o,
    output logic               sec_level_o,
    output logic               blink_o,
    output logic [STATE_W-1:0] state_o
);

    if (!timebase_legal(CLK_HZ, SCAN_HZ, BLINK_HZ, FAST_HZ)) begin : g_bad
        $error("timebase_ctrl: rate parameters do not divide evenly");
    end

    localparam int unsigned PRE  = CLK_HZ / SCAN_HZ;
    localparam int unsigned FDIV = SCAN_HZ / FAST_HZ;
    localparam int unsigned BDIV = SCAN_HZ / (2 * BLINK_HZ);

    localparam int PRE_W = cnt_width(PRE);
    localparam int SUB_W = cnt_width(SCAN_HZ);
    localparam int FST_W = cnt_width(FDIV);
    localparam int BLK_W = cnt_width(BDIV);

    localparam logic [SUB_W-1:0] HALF = SUB_W'(SCAN_HZ / 2);

    state_e state_q, state_d;
    logic   cnt_clr;

    logic [PRE_W-1:0] pre_cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic [FST_W-1:0] fast_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic [SUB_W-1:0] sub_nxt;

    logic scan_wrap, sub_wrap, fast_wrap, blink_wrap;
    logic sub_en, fast_en;

    logic scan_tick_q, scan_tick_d;
    logic sec_tick_q,  sec_tick_d;
    logic fast_tick_q, fast_tick_d;
    logic sec_level_q, sec_level_d;
    logic blink_q,     blink_d;

    logic unused_cnt;
    assign unused_cnt = ^{pre_cnt, fast_cnt, blink_cnt};

    // Mode select: fast beats run, otherwise pause.
    always_comb begin
        state_d = state_q;
        priority case (1'b1)
            fast_i:  state_d = FAST;
            run_i:   state_d = RUN;
            default: state_d = PAUSED;
        endcase
    end

    assign cnt_clr = resync_i | (state_d != state_q);
    assign sub_en  = scan_wrap & (state_q == RUN);
    assign fast_en = scan_wrap & (state_q == FAST);

    mod_counter #(.MOD(PRE)) u_pre (
        .clk_i (clk_i),
        .reset (reset),
        .en    (1'b1),
        .clr   (resync_i),
        .cnt   (pre_cnt),
        .wrap  (scan_wrap)
    );

    mod_counter #(.MOD(SCAN_HZ)) u_sub (
        .clk_i (clk_i),
        .reset (reset),
        .en    (sub_en),
        .clr   (cnt_clr),
        .cnt   (sub_cnt),
        .wrap  (sub_wrap)
    );

    mod_counter #(.MOD(FDIV)) u_fast (
        .clk_i (clk_i),
        .reset (reset),
        .en    (fast_en),
        .clr   (cnt_clr),
        .cnt   (fast_cnt),
        .wrap  (fast_wrap)
    );

    mod_counter #(.MOD(BDIV)) u_blink (
        .clk_i (clk_i),
        .reset (reset),
        .en    (scan_wrap),
        .clr   (1'b0),
        .cnt   (blink_cnt),
        .wrap  (blink_wrap)
    );

    // Output next-values; sec level looks at the post-edge sub count.
    always_comb begin
        sub_nxt = sub_cnt;
        if (cnt_clr || sub_wrap) sub_nxt = '0;
        else if (sub_en)         sub_nxt = sub_cnt + 1'b1;
        scan_tick_d = scan_wrap;
        sec_tick_d  = sub_wrap;
        fast_tick_d = fast_wrap;
        blink_d     = blink_q ^ blink_wrap;
        sec_level_d = (state_d == RUN) && (sub_nxt < HALF);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q     <= PAUSED;
            scan_tick_q <= 1'b0;
            sec_tick_q  <= 1'b0;
            fast_tick_q <= 1'b0;
            sec_level_q <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_tick_q <= scan_tick_d;
            sec_tick_q  <= sec_tick_d;
            fast_tick_q <= fast_tick_d;
            sec_level_q <= sec_level_d;
            blink_q     <= blink_d;
        end
    end

    assign scan_tick_o = scan_tick_q;
    assign sec_tick_o  = sec_tick_q;
    assign fast_tick_o = fast_tick_q;
    assign sec_level_o = sec_level_q;
    assign blink_o     = blink_q;
    assign state_o     = state_q;

endmodule
